// File: rtl/wmem_banked_pm.sv
// Banked weight memory: one request port decoded onto NUM_BANKS behavioural SRAM banks,
// each with its own idle-timeout sleep / fixed-latency wake controller.
module wmem_banked_pm #(
    parameter int DATA_BIT    = 128,
    parameter int NUM_BANKS   = 3,
    parameter int BANK_DEPTH  = 512,
    parameter int ADDR_WIDTH  = $clog2(NUM_BANKS * BANK_DEPTH),
    parameter int IDLE_CYCLES = 64,
    parameter int WAKE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_BIT-1:0]   req_wdata,
    input  logic [DATA_BIT-1:0]   req_bwe,
    output logic                  rsp_valid,
    output logic [DATA_BIT-1:0]   rsp_rdata,
    output logic                  oor_err,
    input  logic                  sleep_en,
    output logic [NUM_BANKS-1:0]  bank_awake
);

    localparam int ROW_W  = $clog2(BANK_DEPTH);
    localparam int IDLE_W = $clog2(IDLE_CYCLES);
    localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_MAX = WAKE_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        AWAKE  = 2'd0,
        SLEEP  = 2'd1,
        WAKING = 2'd2
    } bank_state_t;

    bank_state_t         state_q  [NUM_BANKS];
    logic [IDLE_W-1:0]   idle_cnt [NUM_BANKS];
    logic [WAKE_W-1:0]   wake_cnt [NUM_BANKS];
    logic [DATA_BIT-1:0] mem      [NUM_BANKS][BANK_DEPTH];

    logic [ADDR_WIDTH-1:0] bank_full;
    logic [ROW_W-1:0]      row;
    logic                  oor;
    logic [NUM_BANKS-1:0]  sel;
    logic                  accept;

    // Bank index kept at full address width so out-of-range indices compare cleanly.
    assign bank_full = req_addr >> ROW_W;
    assign row       = req_addr[ROW_W-1:0];
    assign oor       = (bank_full >= ADDR_WIDTH'(NUM_BANKS));

    always_comb begin
        sel        = '0;
        bank_awake = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            sel[i]        = (bank_full == ADDR_WIDTH'(i));
            bank_awake[i] = (state_q[i] == AWAKE);
        end
    end

    // valid/ready: a request is taken on a cycle where req_valid & req_ready are both high;
    // the requester holds all req_* stable until then.
    assign req_ready = oor | (|(sel & bank_awake));
    assign accept    = req_valid & req_ready & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                state_q[i]  <= AWAKE;
                idle_cnt[i] <= '0;
                wake_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                case (state_q[i])
                    AWAKE: begin
                        // An access on the timeout cycle keeps the bank awake.
                        if (accept && sel[i]) begin
                            idle_cnt[i] <= '0;
                        end else if (idle_cnt[i] == IDLE_MAX && sleep_en) begin
                            state_q[i] <= SLEEP;
                        end else if (idle_cnt[i] != IDLE_MAX) begin
                            idle_cnt[i] <= idle_cnt[i] + 1'b1;
                        end
                    end
                    SLEEP: begin
                        if ((req_valid && sel[i]) || !sleep_en) begin
                            state_q[i]  <= WAKING;
                            wake_cnt[i] <= '0;
                        end
                    end
                    WAKING: begin
                        if (wake_cnt[i] == WAKE_MAX) begin
                            state_q[i]  <= AWAKE;
                            idle_cnt[i] <= '0;
                        end else begin
                            wake_cnt[i] <= wake_cnt[i] + 1'b1;
                        end
                    end
                    default: state_q[i] <= AWAKE;
                endcase
            end
        end
    end

    // Array is only touched on accepted requests, which implies the bank is AWAKE.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (accept && req_wen && sel[i]) begin
                mem[i][row] <= (mem[i][row] & ~req_bwe) | (req_wdata & req_bwe);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            oor_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= accept & ~req_wen;
            oor_err   <= accept & oor;
            if (accept && !req_wen) begin
                if (oor) begin
                    rsp_rdata <= '0;
                end else begin
                    for (int i = 0; i < NUM_BANKS; i++) begin
                        if (sel[i]) rsp_rdata <= mem[i][row];
                    end
                end
            end
        end
    end

endmodule
